// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: RV32I funct3
// encodings, the FSM state type and the request-classification helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDC,
        WR,
        RESP
    } lsu_state_t;

    // Stores only support SB/SH/SW; loads reject the three unused codes.
    function automatic logic lsu_is_illegal(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            return (funct3 > F3_W);
        end
        return (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    endfunction

    // Halfwords need an even address, words need a word-aligned address.
    function automatic logic lsu_is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return (addr_lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic: extracts and extends load data from a
// raw memory word, and merges sub-word store data into a read-back word.
// Lanes are little-endian: byte k lives in bits [8k+7:8k].
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] store_word
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [31:0] byte_lane;
    logic [31:0] half_lane;

    // Move the addressed byte/halfword down to bit 0 for extension.
    always_comb begin
        byte_shift = {addr_lo, 3'b000};
        half_shift = {addr_lo[1], 4'b0000};
        byte_lane  = raw_word >> byte_shift;
        half_lane  = raw_word >> half_shift;
    end

    // Load extension: signed for LB/LH, zero for LBU/LHU, pass-through for LW.
    always_comb begin
        load_value = '0;
        case (funct3)
            F3_B:    load_value = {{24{byte_lane[7]}}, byte_lane[7:0]};
            F3_H:    load_value = {{16{half_lane[15]}}, half_lane[15:0]};
            F3_W:    load_value = raw_word;
            F3_BU:   load_value = {24'd0, byte_lane[7:0]};
            F3_HU:   load_value = {16'd0, half_lane[15:0]};
            default: load_value = '0;
        endcase
    end

    // Store merge: clear the target lane in the read-back word and OR in the new data.
    always_comb begin
        store_word = raw_word;
        case (funct3)
            F3_B: store_word = (raw_word & ~(32'h0000_00FF << byte_shift))
                             | ({24'd0, store_data[7:0]} << byte_shift);
            F3_H: store_word = (raw_word & ~(32'h0000_FFFF << half_shift))
                             | ({16'd0, store_data[15:0]} << half_shift);
            F3_W: store_word = store_data;
            default: store_word = raw_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Memory-stage load/store initiator for the single-port word-addressed
// DataMemory. One request at a time; sub-word stores are done as
// read-modify-write; misaligned and illegal requests never touch memory.
// All outputs are registered and loaded from the next-state value, so each
// output is high exactly while the FSM sits in the matching state.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misaligned,
    output logic              resp_illegal,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        state;
    lsu_state_t        state_next;

    logic              cap_is_store;
    logic [2:0]        cap_funct3;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic              req_accept;
    logic              req_illegal;
    logic              req_misaligned;
    logic              req_error;
    logic [ADDR_W-1:0] word_addr_next;

    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] store_word;

    // Lane logic always works on the captured request and the live read data,
    // which is only meaningful while in RDC.
    lsu_align u_align (
        .funct3     (cap_funct3),
        .addr_lo    (cap_addr[1:0]),
        .raw_word   (mem_rdata),
        .store_data (cap_wdata),
        .load_value (load_value),
        .store_word (store_word)
    );

    // Classify the incoming request; illegal wins so at most one flag is set.
    always_comb begin
        req_accept     = (state == IDLE) && req_valid;
        req_illegal    = lsu_is_illegal(req_is_store, req_funct3);
        req_misaligned = !req_illegal && lsu_is_misaligned(req_funct3, req_addr[1:0]);
        req_error      = req_illegal || req_misaligned;
        word_addr_next = req_accept ? {req_addr[ADDR_W-1:2], 2'b00}
                                    : {cap_addr[ADDR_W-1:2], 2'b00};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: errors skip memory, SW writes directly, everything else reads first.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_error) begin
                        state_next = RESP;
                    end else if (req_is_store && (req_funct3 == F3_W)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD:      state_next = RDC;
            RDC:     state_next = cap_is_store ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture all request fields on the accept edge; they stay put for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_is_store <= 1'b0;
            cap_funct3   <= '0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
        end else if (req_accept) begin
            cap_is_store <= req_is_store;
            cap_funct3   <= req_funct3;
            cap_addr     <= req_addr;
            cap_wdata    <= req_wdata;
        end
    end

    // Handshake and memory strobes, registered from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready <= 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            req_ready <= (state_next == IDLE);
            mem_read  <= (state_next == RD);
            mem_write <= (state_next == WR);
            if ((state_next == RD) || (state_next == WR)) begin
                mem_addr <= word_addr_next;
            end else begin
                mem_addr <= '0;
            end
            if (state_next == WR) begin
                mem_wdata <= req_accept ? req_wdata : store_word;
            end else begin
                mem_wdata <= '0;
            end
        end
    end

    // Response pulse plus result/flags, which are refreshed only when entering RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            resp_illegal    <= 1'b0;
        end else begin
            resp_valid <= (state_next == RESP);
            if (state_next == RESP) begin
                if (req_accept) begin
                    resp_rdata      <= '0;
                    resp_misaligned <= req_misaligned;
                    resp_illegal    <= req_illegal;
                end else if ((state == RDC) && !cap_is_store) begin
                    resp_rdata      <= load_value;
                    resp_misaligned <= 1'b0;
                    resp_illegal    <= 1'b0;
                end else begin
                    resp_rdata      <= '0;
                    resp_misaligned <= 1'b0;
                    resp_illegal    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed scenarios followed by
// random requests, each compared against a word-array reference model.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_illegal;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] init_vals [0:63];
    logic [31:0] dmem      [0:63];
    logic [31:0] refmem    [0:63];
    logic        mem_init;

    logic [31:0] exp_lat, exp_rd_at, exp_wr_at, exp_rdata, exp_mis, exp_ill, exp_addr, exp_wdata;
    logic [31:0] obs_lat, obs_rd_at, obs_wr_at, obs_rd_cnt, obs_wr_cnt, obs_overlap;
    logic [31:0] obs_addr, obs_wdata, obs_rdata, obs_mis, obs_ill, obs_ready_busy;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_store    (req_is_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .resp_illegal    (resp_illegal),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata)
    );

    // Stand-in for DataMemory: synchronous read, data valid the cycle after mem_read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) dmem[i] <= init_vals[i];
            mem_rdata <= '0;
        end else begin
            if (mem_write) dmem[mem_addr[7:2]] <= mem_wdata;
            if (mem_read) mem_rdata <= dmem[mem_addr[7:2]];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model: decides the outcome from the architectural rules and updates refmem.
    task automatic refModel(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        int          bl;
        int          hl;
        exp_lat = 0; exp_rd_at = 0; exp_wr_at = 0; exp_rdata = 0; exp_wdata = 0;
        exp_ill = {31'd0, st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)};
        exp_mis = {31'd0, (exp_ill == 0) && (((f3[1:0] == 2'd1) && a[0]) ||
                                             ((f3[1:0] == 2'd2) && (a[1:0] != 2'd0)))};
        exp_addr = {a[31:2], 2'b00};
        bl = int'(a[1:0]);
        hl = int'(a[1]);
        w = refmem[a[7:2]];
        b = w[8*bl +: 8];
        h = w[16*hl +: 16];
        if (exp_ill != 0 || exp_mis != 0) begin
            exp_lat = 1;
        end else if (!st) begin
            exp_lat = 3;
            exp_rd_at = 1;
            case (f3)
                3'd0: exp_rdata = int'($signed(b));
                3'd1: exp_rdata = int'($signed(h));
                3'd2: exp_rdata = w;
                3'd4: exp_rdata = {24'd0, b};
                default: exp_rdata = {16'd0, h};
            endcase
        end else if (f3 == 3'd2) begin
            exp_lat = 2;
            exp_wr_at = 1;
            exp_wdata = wd;
            refmem[a[7:2]] = wd;
        end else begin
            exp_lat = 4;
            exp_rd_at = 1;
            exp_wr_at = 3;
            if (f3 == 3'd0) w[8*bl +: 8] = wd[7:0];
            else w[16*hl +: 16] = wd[15:0];
            exp_wdata = w;
            refmem[a[7:2]] = w;
        end
    endtask

    // Drive one request, then watch the DUT cycle by cycle until the response (bounded).
    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int waitc;
        obs_lat = 0; obs_rd_at = 0; obs_wr_at = 0; obs_rd_cnt = 0; obs_wr_cnt = 0;
        obs_overlap = 0; obs_addr = 0; obs_wdata = 0; obs_rdata = 0; obs_mis = 0; obs_ill = 0;
        obs_ready_busy = 0;
        waitc = 0;
        @(negedge clk);
        while (!req_ready && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_read && mem_write) obs_overlap = 1;
            if (req_ready) obs_ready_busy = 1;
            if (mem_read) begin
                obs_rd_cnt = obs_rd_cnt + 1; obs_rd_at = 32'(k); obs_addr = mem_addr;
            end
            if (mem_write) begin
                obs_wr_cnt = obs_wr_cnt + 1; obs_wr_at = 32'(k); obs_addr = mem_addr; obs_wdata = mem_wdata;
            end
            if (resp_valid) begin
                obs_lat = 32'(k);
                obs_rdata = resp_rdata;
                obs_mis = {31'd0, resp_misaligned};
                obs_ill = {31'd0, resp_illegal};
                break;
            end
        end
    endtask

    task automatic runVector(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        refModel(st, f3, a, wd);
        applyStimulus(st, f3, a, wd);
        checkOutput({tag, ".latency"}, obs_lat, exp_lat);
        checkOutput({tag, ".rdata"}, obs_rdata, exp_rdata);
        checkOutput({tag, ".misaligned"}, obs_mis, exp_mis);
        checkOutput({tag, ".illegal"}, obs_ill, exp_ill);
        checkOutput({tag, ".rd_cycle"}, obs_rd_at, exp_rd_at);
        checkOutput({tag, ".wr_cycle"}, obs_wr_at, exp_wr_at);
        checkOutput({tag, ".rd_count"}, obs_rd_cnt, (exp_rd_at != 0) ? 32'd1 : 32'd0);
        checkOutput({tag, ".wr_count"}, obs_wr_cnt, (exp_wr_at != 0) ? 32'd1 : 32'd0);
        checkOutput({tag, ".overlap"}, obs_overlap, 32'd0);
        checkOutput({tag, ".ready_busy"}, obs_ready_busy, 32'd0);
        if (exp_rd_at != 0 || exp_wr_at != 0) checkOutput({tag, ".mem_addr"}, obs_addr, exp_addr);
        if (exp_wr_at != 0) checkOutput({tag, ".mem_wdata"}, obs_wdata, exp_wdata);
    endtask

    logic        bq_st [0:2];
    logic [2:0]  bq_f3 [0:2];
    logic [31:0] bq_a  [0:2];
    logic [31:0] bq_wd [0:2];
    logic [31:0] bq_exp[0:2];
    int acc, resp_cnt, overlap_cnt, ready_hi, extra_resp;
    logic will_accept;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            init_vals[i] = $urandom;
            refmem[i] = init_vals[i];
        end
        mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; mem_init = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("reset.req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset.resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("reset.mem_read", {31'd0, mem_read}, 32'd0);
        checkOutput("reset.mem_write", {31'd0, mem_write}, 32'd0);
        checkOutput("reset.mem_addr", mem_addr, 32'd0);
        checkOutput("reset.mem_wdata", mem_wdata, 32'd0);
        checkOutput("reset.resp_rdata", resp_rdata, 32'd0);
        checkOutput("reset.flags", {30'd0, resp_misaligned, resp_illegal}, 32'd0);

        // Word store/load and lane extraction over 0xAABBCCDD
        runVector("sw_0x4", 1'b1, 3'd2, 32'h4, 32'hAABB_CCDD);
        checkOutput("sw_0x4.const_wdata", obs_wdata, 32'hAABB_CCDD);
        runVector("lw_0x4", 1'b0, 3'd2, 32'h4, 32'h0);
        checkOutput("lw_0x4.const", obs_rdata, 32'hAABB_CCDD);
        runVector("lb_0x5", 1'b0, 3'd0, 32'h5, 32'h0);
        checkOutput("lb_0x5.const", obs_rdata, 32'hFFFF_FFCC);
        runVector("lbu_0x5", 1'b0, 3'd4, 32'h5, 32'h0);
        checkOutput("lbu_0x5.const", obs_rdata, 32'h0000_00CC);
        runVector("lh_0x6", 1'b0, 3'd1, 32'h6, 32'h0);
        checkOutput("lh_0x6.const", obs_rdata, 32'hFFFF_AABB);
        runVector("lhu_0x4", 1'b0, 3'd5, 32'h4, 32'h0);
        checkOutput("lhu_0x4.const", obs_rdata, 32'h0000_CCDD);

        // Sub-word read-modify-write
        runVector("sb_0x6", 1'b1, 3'd0, 32'h6, 32'h0000_0011);
        checkOutput("sb_0x6.const", obs_wdata, 32'hAA11_CCDD);
        runVector("sh_0x4", 1'b1, 3'd1, 32'h4, 32'h0000_1234);
        checkOutput("sh_0x4.const", obs_wdata, 32'hAA11_1234);

        // Error requests
        runVector("lw_mis_0x6", 1'b0, 3'd2, 32'h6, 32'h0);
        runVector("sh_mis_0x3", 1'b1, 3'd1, 32'h3, 32'hFFFF);
        runVector("ld_ill_f3", 1'b0, 3'd3, 32'h8, 32'h0);
        runVector("st_ill_f3", 1'b1, 3'd6, 32'h8, 32'h0);

        // Top-of-address-space word is passed through unchanged
        runVector("sw_wrap", 1'b1, 3'd2, 32'hFFFF_FFFC, 32'h1357_9BDF);
        runVector("lw_wrap", 1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0);

        // Back-to-back: req_valid held high across three queued requests
        bq_st[0] = 1'b1; bq_f3[0] = 3'd2; bq_a[0] = 32'h10; bq_wd[0] = 32'h1234_5678;
        bq_st[1] = 1'b0; bq_f3[1] = 3'd1; bq_a[1] = 32'h12; bq_wd[1] = 32'h0;
        bq_st[2] = 1'b0; bq_f3[2] = 3'd4; bq_a[2] = 32'h13; bq_wd[2] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            refModel(bq_st[i], bq_f3[i], bq_a[i], bq_wd[i]);
            bq_exp[i] = exp_rdata;
        end
        acc = 0; resp_cnt = 0; overlap_cnt = 0; ready_hi = 0; extra_resp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = bq_st[0]; req_funct3 = bq_f3[0]; req_addr = bq_a[0]; req_wdata = bq_wd[0];
        for (int cyc = 0; cyc < 40 && resp_cnt < 3; cyc++) begin
            if (mem_read && mem_write) overlap_cnt++;
            if (req_ready) ready_hi++;
            if (resp_valid) begin
                if (resp_cnt < 3) checkOutput($sformatf("b2b%0d.rdata", resp_cnt), resp_rdata, bq_exp[resp_cnt]);
                resp_cnt++;
            end
            will_accept = req_ready && req_valid;
            @(posedge clk);
            #1;
            if (will_accept) begin
                acc++;
                if (acc < 3) begin
                    req_is_store = bq_st[acc]; req_funct3 = bq_f3[acc]; req_addr = bq_a[acc]; req_wdata = bq_wd[acc];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        repeat (6) begin
            if (resp_valid) extra_resp++;
            @(negedge clk);
        end
        checkOutput("b2b.accepted", 32'(acc), 32'd3);
        checkOutput("b2b.responses", 32'(resp_cnt), 32'd3);
        checkOutput("b2b.ready_cycles", 32'(ready_hi), 32'd3);
        checkOutput("b2b.overlap", 32'(overlap_cnt), 32'd0);
        checkOutput("b2b.extra_resp", 32'(extra_resp), 32'd0);

        // Reset asserted while an SB sits in its write cycle
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h21; req_wdata = 32'h5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 checkOutput("rst_mid.in_write", {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid.mem_write", {31'd0, mem_write}, 32'd0);
        checkOutput("rst_mid.mem_read", {31'd0, mem_read}, 32'd0);
        checkOutput("rst_mid.req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_mid.resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_mid.mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mid.mem_wdata", mem_wdata, 32'd0);
        extra_resp = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) extra_resp++;
        end
        checkOutput("rst_mid.no_resp", 32'(extra_resp), 32'd0);
        runVector("rst_lw", 1'b0, 3'd2, 32'h10, 32'h0);

        // Random requests away from the word disturbed by the aborted store
        for (int n = 0; n < 60; n++) begin
            runVector($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      32'h40 + 32'($urandom_range(0, 191)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
